// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_sequencer_pkg                                              |
// | Purpose  : Shared definitions for the fetch sequencer: address/word/imm    |
// |            types, opcode and sequencer-state encodings, default reset PC   |
// |            and field-extraction helpers.                                   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fetch_sequencer_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] word_t;
   typedef logic [15:0] imm_t;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_BEQ   = 6'b000100,
      OP_BNE   = 6'b000101
   } opcode_t;

   typedef enum logic [2:0] {
      S_FETCH           = 3'd0,
      S_FETCH_ADDR_SENT = 3'd1,
      S_DECODE          = 3'd2,
      S_BRANCH_EVAL     = 3'd3,
      S_BRANCH          = 3'd4,
      S_COMMIT          = 3'd5,
      S_UNKNOWN         = 3'd6
   } cpu_state_t;

   localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;
   localparam addr_t c_PC_STEP        = 32'd4;

   function automatic opcode_t get_opcode(input word_t w);
      return opcode_t'(w[31:26]);
   endfunction

   function automatic imm_t get_imm(input word_t w);
      return w[15:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_sequencer_if                                               |
// | Purpose  : Instruction-fetch request/response bundle.                      |
// | Ports    : ireq_valid/ireq_addr   request from sequencer                   |
// |            iresp_addr_ok          address accepted by memory               |
// |            iresp_data_ok/_data    instruction word returned                |
// |            master = sequencer side, slave = memory side                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   logic  ireq_valid;
   addr_t ireq_addr;
   logic  iresp_addr_ok;
   logic  iresp_data_ok;
   word_t iresp_data;

   modport master (
      output ireq_valid, ireq_addr,
      input  iresp_addr_ok, iresp_data_ok, iresp_data
   );

   modport slave (
      input  ireq_valid, ireq_addr,
      output iresp_addr_ok, iresp_data_ok, iresp_data
   );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_unit                                                      |
// | Purpose  : Combinational branch compare and target computation.            |
// | Ports    : opcode, rs_val, rt_val  compare operands (BEQ/BNE)              |
// |            pc, imm                 branch PC and 16-bit word offset        |
// |            taken                   branch condition holds                  |
// |            target                  pc + 4 + (sext(imm) << 2), mod 2^32     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module branch_unit
   import fetch_sequencer_pkg::*;
(
   input  opcode_t opcode,
   input  word_t   rs_val,
   input  word_t   rt_val,
   input  addr_t   pc,
   input  imm_t    imm,
   output logic    taken,
   output addr_t   target
);

   logic  w_equal;
   addr_t w_offset;

   assign w_equal  = (rs_val == rt_val);
   assign w_offset = {{14{imm[15]}}, imm, 2'b00};

   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQ:  taken = w_equal;
         OP_BNE:  taken = !w_equal;
         default: taken = 1'b0;
      endcase
   end

   assign target = pc + c_PC_STEP + w_offset;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                                  |
// | Purpose  : Multi-cycle fetch/decode/branch/commit sequencer with one       |
// |            branch delay slot.                                              |
// | Ports    : clk, reset        clock, synchronous active-high reset          |
// |            bus (master)      instruction fetch request/response            |
// |            rs_idx/rt_idx     register-file read indices from instr         |
// |            rs_val/rt_val     register-file read data                       |
// |            state, pc, instr  sequencer state, in-flight PC, instruction    |
// |            commit            one-cycle retire pulse                        |
// |            halted            high while stuck in S_UNKNOWN                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   fetch_sequencer_if.master  bus,
   output logic [4:0]         rs_idx,
   output logic [4:0]         rt_idx,
   input  word_t              rs_val,
   input  word_t              rt_val,
   output cpu_state_t         state,
   output addr_t              pc,
   output word_t              instr,
   output logic               commit,
   output logic               halted
);

   cpu_state_t r_state;
   addr_t      r_pc;
   addr_t      r_delayed_pc;
   word_t      r_instr;
   logic       r_delayed;
   logic       r_branch_self;
   logic       r_ireq_valid;
   logic       r_commit;
   logic       r_halted;

   opcode_t    w_opcode;
   imm_t       w_imm;
   logic       w_taken;
   addr_t      w_target;

   assign w_opcode = get_opcode(r_instr);
   assign w_imm    = get_imm(r_instr);

   branch_unit u_branch_unit (
      .opcode (w_opcode),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .pc     (r_pc),
      .imm    (w_imm),
      .taken  (w_taken),
      .target (w_target)
   );

   // Outputs are registered: each transition also sets the output values
   // that belong to the destination state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_delayed     <= 1'b0;
         r_branch_self <= 1'b0;
         r_delayed_pc  <= '0;
         r_ireq_valid  <= 1'b1;
         r_commit      <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         r_commit <= 1'b0;
         case (r_state)
            S_FETCH: begin
               // data_ok on its own is a stale response and is dropped
               if (bus.iresp_addr_ok) begin
                  r_ireq_valid <= 1'b0;
                  if (bus.iresp_data_ok) begin
                     r_instr <= bus.iresp_data;
                     r_state <= S_DECODE;
                  end else begin
                     r_state <= S_FETCH_ADDR_SENT;
                  end
               end
            end
            S_FETCH_ADDR_SENT: begin
               if (bus.iresp_data_ok) begin
                  r_instr <= bus.iresp_data;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (w_opcode)
                  OP_RTYPE: begin
                     r_state  <= S_COMMIT;
                     r_commit <= 1'b1;
                  end
                  OP_BEQ, OP_BNE: begin
                     // a branch sitting in a delay slot retires as a plain op
                     if (r_delayed) begin
                        r_state  <= S_COMMIT;
                        r_commit <= 1'b1;
                     end else begin
                        r_state <= S_BRANCH_EVAL;
                     end
                  end
                  default: begin
                     r_state  <= S_UNKNOWN;
                     r_halted <= 1'b1;
                  end
               endcase
            end
            S_BRANCH_EVAL: begin
               if (w_taken) begin
                  r_state <= S_BRANCH;
               end else begin
                  r_state  <= S_COMMIT;
                  r_commit <= 1'b1;
               end
            end
            S_BRANCH: begin
               r_delayed_pc  <= w_target;
               r_delayed     <= 1'b1;
               r_branch_self <= 1'b1;
               r_state       <= S_COMMIT;
               r_commit      <= 1'b1;
            end
            S_COMMIT: begin
               // branch_self marks the branch itself retiring: step into the
               // delay slot first, redirect when the slot retires.
               if (r_delayed && !r_branch_self) begin
                  r_pc      <= r_delayed_pc;
                  r_delayed <= 1'b0;
               end else begin
                  r_pc <= r_pc + c_PC_STEP;
               end
               r_branch_self <= 1'b0;
               r_state       <= S_FETCH;
               r_ireq_valid  <= 1'b1;
            end
            S_UNKNOWN: begin
               r_state <= S_UNKNOWN;
            end
            default: begin
               r_state      <= S_UNKNOWN;
               r_halted     <= 1'b1;
               r_ireq_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ireq_valid = r_ireq_valid;
   assign bus.ireq_addr  = r_pc;
   assign rs_idx         = r_instr[25:21];
   assign rt_idx         = r_instr[20:16];
   assign state          = r_state;
   assign pc             = r_pc;
   assign instr          = r_instr;
   assign commit         = r_commit;
   assign halted         = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_sequencer                                               |
// | Purpose  : Self-checking bench for fetch_sequencer: directed sequences,    |
// |            a table of single-branch programs and a randomized run against |
// |            an instruction-level model of the delay-slot PC behaviour.      |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam addr_t c_RESET_PC = 32'h0000_0000;
   localparam word_t c_NOP      = 32'h0000_0020;

   logic        clk;
   logic        reset;
   logic [4:0]  rs_idx;
   logic [4:0]  rt_idx;
   word_t       rs_val;
   word_t       rt_val;
   cpu_state_t  state_o;
   addr_t       pc_o;
   word_t       instr_o;
   logic        commit;
   logic        halted;
   word_t       regs [32];

   int n_vec = 0;
   int n_err = 0;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.RESET_PC(c_RESET_PC)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .rs_idx (rs_idx),
      .rt_idx (rt_idx),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .state  (state_o),
      .pc     (pc_o),
      .instr  (instr_o),
      .commit (commit),
      .halted (halted)
   );

   assign rs_val = regs[rs_idx];
   assign rt_val = regs[rt_idx];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string name;
      word_t instr0;
      word_t rs_v;
      word_t rt_v;
      addr_t f1;
      addr_t f2;
      addr_t f3;
      bit    halt;
   } vec_t;

   vec_t tbl [$];

   // instruction-level model state for the random run
   addr_t m_pc;
   addr_t m_tgt;
   bit    m_slot;
   int    consumed;

   function automatic word_t enc(input logic [5:0] op, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic addr_t br_target(input addr_t p, input logic [15:0] im);
      logic signed [31:0] s;
      s = {{16{im[15]}}, im};
      return p + 32'd4 + 32'(s * 4);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      bus.iresp_addr_ok = 1'b0;
      bus.iresp_data_ok = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // wait (bounded) for a request, check its address, return the word at once
   task automatic deliver(input string nm, input word_t w, input addr_t exp_addr);
      int k;
      k = 0;
      while (!bus.ireq_valid && k < 20) begin
         tick();
         k++;
      end
      chk({nm, " req"}, 32'(bus.ireq_valid), 32'd1);
      chk({nm, " addr"}, bus.ireq_addr, exp_addr);
      bus.iresp_addr_ok = 1'b1;
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = w;
      tick();
      bus.iresp_addr_ok = 1'b0;
      bus.iresp_data_ok = 1'b0;
   endtask

   function automatic word_t gen_instr();
      int    r;
      logic [5:0]  op;
      logic [15:0] imm;
      r   = $urandom_range(0, 3);
      op  = (r < 2) ? 6'h00 : ((r == 2) ? 6'h04 : 6'h05);
      imm = 16'($urandom_range(0, 255)) - 16'd128;
      return enc(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
   endfunction

   // one instruction retires: sequential PC unless a taken branch has
   // opened a delay slot, in which case the slot's successor is the target
   task automatic model_consume(input word_t w);
      logic [5:0] op;
      bit         tk;
      op = w[31:26];
      tk = (op == 6'h04 && regs[w[25:21]] == regs[w[20:16]]) ||
           (op == 6'h05 && regs[w[25:21]] != regs[w[20:16]]);
      if (m_slot) begin
         m_pc   = m_tgt;
         m_slot = 1'b0;
      end else if (tk) begin
         m_tgt  = br_target(m_pc, w[15:0]);
         m_slot = 1'b1;
         m_pc   = m_pc + 32'd4;
      end else begin
         m_pc = m_pc + 32'd4;
      end
      consumed++;
   endtask

   initial begin
      bit    saw_req;
      bit    saw_commit;
      int    commits;
      int    phase;
      int    cnt;
      int    lat;
      word_t cur;

      reset = 1'b1;
      bus.iresp_addr_ok = 1'b0;
      bus.iresp_data_ok = 1'b0;
      bus.iresp_data    = '0;
      for (int i = 0; i < 32; i++) regs[i] = '0;

      tbl.push_back('{"rtype",    enc(6'h00, 5'd1, 5'd2, 16'h0020), 32'd0, 32'd0, 32'h4, 32'h8,         32'hC,         1'b0});
      tbl.push_back('{"bne_eq",   enc(6'h05, 5'd1, 5'd2, 16'h0010), 32'd7, 32'd7, 32'h4, 32'h8,         32'hC,         1'b0});
      tbl.push_back('{"bne_ne",   enc(6'h05, 5'd1, 5'd2, 16'h0010), 32'd3, 32'd7, 32'h4, 32'h44,        32'h48,        1'b0});
      tbl.push_back('{"beq_eq",   enc(6'h04, 5'd1, 5'd2, 16'h0010), 32'd5, 32'd5, 32'h4, 32'h44,        32'h48,        1'b0});
      tbl.push_back('{"beq_ne",   enc(6'h04, 5'd1, 5'd2, 16'h0010), 32'd5, 32'd6, 32'h4, 32'h8,         32'hC,         1'b0});
      tbl.push_back('{"beq_self", enc(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'd5, 32'd5, 32'h4, 32'h0,         32'h4,         1'b0});
      tbl.push_back('{"beq_wrap", enc(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'd9, 32'd9, 32'h4, 32'hFFFF_FFFC, 32'h0,         1'b0});
      tbl.push_back('{"beq_far",  enc(6'h04, 5'd1, 5'd2, 16'h8000), 32'd1, 32'd1, 32'h4, 32'hFFFE_0004, 32'hFFFE_0008, 1'b0});
      tbl.push_back('{"op3f",     enc(6'h3F, 5'd1, 5'd2, 16'h0000), 32'd0, 32'd0, 32'h0, 32'h0,         32'h0,         1'b1});
      tbl.push_back('{"opj",      enc(6'h02, 5'd1, 5'd2, 16'h0004), 32'd0, 32'd0, 32'h0, 32'h0,         32'h0,         1'b1});

      // ---------------- reset state and single-cycle fetch ----------------
      tick();
      tick();
      chk("rst state",  32'(state_o), 32'(S_FETCH));
      chk("rst pc",     pc_o, c_RESET_PC);
      chk("rst instr",  instr_o, 32'd0);
      chk("rst commit", 32'(commit), 32'd0);
      chk("rst halted", 32'(halted), 32'd0);
      chk("rst req",    32'(bus.ireq_valid), 32'd1);
      reset = 1'b0;
      tick();
      chk("post rst req",  32'(bus.ireq_valid), 32'd1);
      chk("post rst addr", bus.ireq_addr, c_RESET_PC);
      bus.iresp_addr_ok = 1'b1;
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = c_NOP;
      tick();
      bus.iresp_addr_ok = 1'b0;
      bus.iresp_data_ok = 1'b0;
      chk("seq decode",   32'(state_o), 32'(S_DECODE));
      chk("seq instr",    instr_o, c_NOP);
      tick();
      chk("seq commit st", 32'(state_o), 32'(S_COMMIT));
      chk("seq commit",    32'(commit), 32'd1);
      tick();
      chk("seq fetch st", 32'(state_o), 32'(S_FETCH));
      chk("seq commit lo", 32'(commit), 32'd0);
      chk("seq next addr", bus.ireq_addr, 32'h4);

      // ---------------- split address/data handshake ----------------
      bus.iresp_addr_ok = 1'b1;
      tick();
      bus.iresp_addr_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("split state", 32'(state_o), 32'(S_FETCH_ADDR_SENT));
         chk("split req",   32'(bus.ireq_valid), 32'd0);
         if (i < 2) tick();
      end
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = 32'h012A_4020;
      tick();
      bus.iresp_data_ok = 1'b0;
      chk("split latch", instr_o, 32'h012A_4020);
      chk("split dec",   32'(state_o), 32'(S_DECODE));
      deliver("split next", c_NOP, 32'h8);

      // ---------------- table of short programs ----------------
      foreach (tbl[v]) begin
         do_reset();
         regs[1] = tbl[v].rs_v;
         regs[2] = tbl[v].rt_v;
         deliver({tbl[v].name, " f0"}, tbl[v].instr0, c_RESET_PC);
         if (tbl[v].halt) begin
            saw_req    = 1'b0;
            saw_commit = 1'b0;
            for (int i = 0; i < 8; i++) begin
               tick();
               saw_req    |= bus.ireq_valid;
               saw_commit |= commit;
            end
            chk({tbl[v].name, " halted"},    32'(halted), 32'd1);
            chk({tbl[v].name, " state"},     32'(state_o), 32'(S_UNKNOWN));
            chk({tbl[v].name, " no req"},    32'(saw_req), 32'd0);
            chk({tbl[v].name, " no commit"}, 32'(saw_commit), 32'd0);
            do_reset();
            chk({tbl[v].name, " unhalt"},  32'(halted), 32'd0);
            chk({tbl[v].name, " rst req"}, 32'(bus.ireq_valid), 32'd1);
            chk({tbl[v].name, " rst pc"},  bus.ireq_addr, c_RESET_PC);
         end else begin
            deliver({tbl[v].name, " f1"}, c_NOP, tbl[v].f1);
            deliver({tbl[v].name, " f2"}, c_NOP, tbl[v].f2);
            deliver({tbl[v].name, " f3"}, c_NOP, tbl[v].f3);
         end
      end

      // ---------------- backward BEQ at 0x100 onto itself ----------------
      do_reset();
      regs[1] = 32'd5;
      regs[2] = 32'd5;
      deliver("jmp0",  enc(6'h04, 5'd1, 5'd2, 16'h003E), 32'h0);
      chk("jmp0 rs_idx", 32'(rs_idx), 32'd1);
      chk("jmp0 rt_idx", 32'(rt_idx), 32'd2);
      deliver("jmp0 slot", c_NOP, 32'h4);
      deliver("at fc",     c_NOP, 32'hFC);
      deliver("beq100",    enc(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h100);
      deliver("slot104",   c_NOP, 32'h104);
      chk("slot pc", pc_o, 32'h104);
      deliver("back100",   c_NOP, 32'h100);
      deliver("after100",  c_NOP, 32'h104);

      // ---------------- branch inside a delay slot is not taken ----------------
      do_reset();
      regs[1] = 32'd2;
      regs[2] = 32'd2;
      deliver("ds br0",   enc(6'h04, 5'd1, 5'd2, 16'h0010), 32'h0);
      deliver("ds slot",  enc(6'h04, 5'd1, 5'd2, 16'h0020), 32'h4);
      deliver("ds tgt",   c_NOP, 32'h44);
      deliver("ds after", c_NOP, 32'h48);

      // ---------------- reset while waiting for data ----------------
      do_reset();
      bus.iresp_addr_ok = 1'b1;
      tick();
      bus.iresp_addr_ok = 1'b0;
      chk("mid rst sent", 32'(state_o), 32'(S_FETCH_ADDR_SENT));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid rst state", 32'(state_o), 32'(S_FETCH));
      tick();
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = c_NOP;
      tick();
      bus.iresp_data_ok = 1'b0;
      chk("stale state", 32'(state_o), 32'(S_FETCH));
      chk("stale instr", instr_o, 32'd0);
      saw_commit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         saw_commit |= commit;
         tick();
      end
      chk("stale commit", 32'(saw_commit), 32'd0);
      deliver("stale recover", c_NOP, c_RESET_PC);

      // ---------------- randomized run against the model ----------------
      do_reset();
      for (int i = 0; i < 32; i++) regs[i] = $urandom_range(0, 3);
      m_pc     = c_RESET_PC;
      m_tgt    = '0;
      m_slot   = 1'b0;
      consumed = 0;
      commits  = 0;
      phase    = 0;
      cnt      = 0;
      cur      = '0;
      for (int cyc = 0; cyc < 20000 && consumed < 300; cyc++) begin
         if (commit) commits++;
         bus.iresp_addr_ok = 1'b0;
         bus.iresp_data_ok = 1'b0;
         if (phase == 0) begin
            if (bus.ireq_valid && cnt == 0) begin
               chk("rnd addr",    bus.ireq_addr, m_pc);
               chk("rnd commits", 32'(commits), 32'(consumed));
               cur = gen_instr();
               bus.iresp_addr_ok = 1'b1;
               lat = $urandom_range(0, 3);
               if (lat == 0) begin
                  bus.iresp_data_ok = 1'b1;
                  bus.iresp_data    = cur;
                  model_consume(cur);
                  cnt = $urandom_range(0, 2);
               end else begin
                  phase = 1;
                  cnt   = lat;
               end
            end else begin
               if (bus.ireq_valid) cnt--;
               // stray response with no address handshake must be dropped
               if ($urandom_range(0, 7) == 0) begin
                  bus.iresp_data_ok = 1'b1;
                  bus.iresp_data    = $urandom;
               end
            end
         end else begin
            cnt--;
            if (cnt == 0) begin
               bus.iresp_data_ok = 1'b1;
               bus.iresp_data    = cur;
               model_consume(cur);
               phase = 0;
               cnt   = $urandom_range(0, 2);
            end
         end
         tick();
      end
      bus.iresp_addr_ok = 1'b0;
      bus.iresp_data_ok = 1'b0;
      chk("rnd progress", 32'(consumed >= 300), 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (commit) commits++;
         tick();
      end
      chk("rnd drain commits", 32'(commits), 32'(consumed));
      chk("rnd drain addr",    bus.ireq_addr, m_pc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the reset: synchronous, active-high.
REQ-004 The block SHALL have port ireq_valid, output, 1, the instruction fetch request.
REQ-005 The block SHALL have port ireq_addr, output, 32, the fetch address.
REQ-006 The block SHALL have port iresp_addr_ok, input, 1, fetch address accepted.
REQ-007 The block SHALL have port iresp_data_ok, input, 1, fetch data valid.
REQ-008 The block SHALL have port iresp_data, input, 32, the instruction word.
REQ-009 The block SHALL have port rs_idx and rt_idx, output, 5 each, the register-file read indices, equal to instr[25:21] and instr[20:16].
REQ-010 The block SHALL have port rs_val and rt_val, input, 32 each, the register-file read data, combinational from the indices.
REQ-011 The block SHALL have port state, output, cpu_state_t, the current sequencer state.
REQ-012 The block SHALL have port pc, output, 32, the PC of the instruction in flight.
REQ-013 The block SHALL have port instr, output, 32, the latched instruction.
REQ-014 The block SHALL have port commit, output, 1, a one-cycle retire pulse.
REQ-015 The block SHALL have port halted, output, 1, high while in S_UNKNOWN.

Function
REQ-016 The sequencer SHALL use states S_FETCH, S_FETCH_ADDR_SENT, S_DECODE, S_BRANCH_EVAL, S_BRANCH, S_COMMIT and S_UNKNOWN.
REQ-017 In S_FETCH the block SHALL drive ireq_valid=1 and ireq_addr=pc, and hold both stable until iresp_addr_ok.
REQ-018 In S_FETCH, addr_ok without data_ok SHALL move to S_FETCH_ADDR_SENT; addr_ok together with data_ok SHALL latch instr and move to S_DECODE.
REQ-019 In S_FETCH_ADDR_SENT, ireq_valid SHALL be 0; data_ok SHALL latch iresp_data into instr and move to S_DECODE; otherwise the state holds.
REQ-020 In any state other than S_FETCH and S_FETCH_ADDR_SENT, data_ok SHALL be ignored (stale responses after reset are dropped).
REQ-021 In S_DECODE, opcode OP_RTYPE SHALL go to S_COMMIT; OP_BEQ and OP_BNE SHALL go to S_BRANCH_EVAL; any other opcode SHALL go to S_UNKNOWN.
REQ-022 In S_BRANCH_EVAL, the branch SHALL be taken when rs_val==rt_val for BEQ, or rs_val!=rt_val for BNE.
REQ-023 A taken branch SHALL move to S_BRANCH; a not-taken branch SHALL move to S_COMMIT.
REQ-024 In S_BRANCH the block SHALL set delayed_pc = pc + 4 + (sign-extended imm << 2), using 32-bit wrap-around arithmetic.
REQ-025 In S_BRANCH the block SHALL set delayed=1 and branch_self=1, then move to S_COMMIT.
REQ-026 In S_COMMIT, commit SHALL be 1 for exactly that cycle, followed by a move to S_FETCH.
REQ-027 The PC update in S_COMMIT SHALL be: if delayed=1 and branch_self=0, pc<=delayed_pc and delayed<=0; otherwise pc<=pc+4. branch_self SHALL clear in every S_COMMIT.
REQ-028 A branch in a delay slot (delayed=1 on entering S_DECODE) SHALL be treated as OP_RTYPE: it is not evaluated and does not alter delayed_pc.
REQ-029 S_UNKNOWN SHALL be absorbing until reset, with halted=1, ireq_valid=0 and commit=0.
REQ-030 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL set state=S_FETCH, pc=RESET_PC, instr=0, delayed=0, branch_self=0 and delayed_pc=0.
REQ-032 During and after reset, outputs SHALL be commit=0 and halted=0, with ireq_valid=1 from the first post-reset cycle.
REQ-033 Reset SHALL take priority over every transition, including reset mid-fetch with a request outstanding.

Structure
REQ-034 The block SHALL reuse cpu_state_t, opcode_t, imm_t and addr_t/word_t from the shared defs package, and SHALL add RESET_PC_DEFAULT to defs; no local enums.
REQ-035 The block SHALL contain one sub-module, branch_unit: a combinational compare-and-target unit taking opcode, rs_val, rt_val, pc and imm, and producing taken and target.

Verification
REQ-036 Reset, then addr_ok=1 and data_ok=1 in the same cycle with data 32'h0000_0020 -> the state sequence is S_FETCH, S_DECODE, S_COMMIT, and the next ireq_addr is 32'h4.
REQ-037 addr_ok in cycle 1 and data_ok in cycle 4 -> the block sits in S_FETCH_ADDR_SENT for 3 cycles with ireq_valid=0, and instr is latched in cycle 4.
REQ-038 BEQ at pc 32'h100 with imm=16'hFFFF and rs_val=rt_val=5 -> the delay slot is fetched at 32'h104, and the fetch after it is at 32'h100.
REQ-039 BNE with rs_val=rt_val=7 -> not taken, commit, and the next fetch is at pc+4.
REQ-040 Opcode 6'b111111 -> S_UNKNOWN, halted=1, and no further ireq_valid until reset; after reset, ireq_addr=RESET_PC.
REQ-041 Reset asserted in S_FETCH_ADDR_SENT, with data_ok arriving 1 cycle after reset release -> the response is ignored only if the state has already been re-entered as S_FETCH with no addr_ok; no spurious commit occurs.
